// File: rtl/dff_bist_pkg.sv
// Shared types and helpers for the D flip-flop self-test controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dff_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        CHK,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Galois feedback mask for the 16-bit right-shifting stimulus LFSR.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    // Cycles spent after the last vector so the two-deep compare pipeline empties.
    localparam int          DRAIN_CYCLES = 2;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/dff_bist_lfsr.sv
// 16-bit Galois LFSR stimulus source with load and advance enables.
// Latency: value reflects a load/advance one cycle after the enabling edge.
// Backpressure: none; state holds whenever advance is low.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-low reset, loads seed
//   load     reload seed (priority over advance)
//   advance  step the LFSR by one position
//   seed     reload value; zero is replaced by 16'h0001 (all-zero locks up)
//   value    low OUT_W bits of the current LFSR state
module dff_bist_lfsr
    import dff_bist_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [15:0]      seed,
    output logic [OUT_W-1:0] value
);

    logic [15:0] lfsr_q;
    logic [15:0] seed_eff;

    assign seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;

    always_ff @(posedge clk) begin
        if (!reset || load) begin
            lfsr_q <= seed_eff;
        end else if (advance) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/dff_bist_ctrl.sv
// Self-test controller: resets a DFF under test, drives NUM_TESTS LFSR vectors, checks q/qbar.
// Latency: done rises NUM_TESTS+4 cycles after the accepted start edge; compares lag dut_d by 2 edges.
// Backpressure: none; start is only sampled in IDLE or DONE and ignored while busy.
//
// Ports:
//   clk, reset (sync active-low)       clocking / reset
//   start                              begin a run (IDLE or DONE only)
//   dut_d, dut_reset                   registered drive to the DFF under test
//   dut_q, dut_qbar                    DFF outputs observed
//   busy, done, pass                   run status; pass valid while done
//   err_cnt, vec_cnt                   saturating mismatch count, vectors applied
//   first_fail, first_fail_vld         only with DFF_BIST_FIRST_FAIL_EN defined:
//                                      index of first failing vector (all-ones = reset check)
module dff_bist_ctrl
    import dff_bist_pkg::*;
#(
    parameter int          NUM_TESTS = 16,
    parameter int          CNT_W     = 8,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             dut_d,
    output logic             dut_reset,
    input  logic             dut_q,
    input  logic             dut_qbar,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
`ifdef DFF_BIST_FIRST_FAIL_EN
    output logic [CNT_W-1:0] first_fail,
    output logic             first_fail_vld,
`endif
    output logic [CNT_W-1:0] vec_cnt
);

    localparam logic [CNT_W-1:0] LAST_VEC  = CNT_W'(NUM_TESTS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam int               DRAIN_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               lfsr_bit;
    logic [DRAIN_W-1:0] drain_cnt;

    // Expected-value pipeline: exp1 holds what the DFF should show once vld2 is set.
    logic               exp1;
    logic               vld1;
    logic               vld2;

    logic               chk_err;
    logic               run_err;
    logic               err_hit;

    dff_bist_lfsr #(
        .OUT_W (1)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .advance (state == RUN),
        .seed    (SEED),
        .value   (lfsr_bit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RST;
                end
            end
            RST:   state_nxt = CHK;
            CHK:   state_nxt = RUN;
            RUN: begin
                if (vec_cnt == LAST_VEC) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RST;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RST) || (state == CHK) || (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0);

    // The DFF was reset during RST, so in CHK it must read q=0, qbar=1.
    // CHK and a valid pipeline compare never coincide, so one edge adds at most one error.
    assign chk_err = (state == CHK) && ((dut_q != 1'b0) || (dut_qbar != 1'b1));
    assign run_err = vld2 && ((dut_q != exp1) || (dut_qbar != ~dut_q));
    assign err_hit = chk_err || run_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            dut_d     <= 1'b0;
            dut_reset <= 1'b0;
            err_cnt   <= '0;
            vec_cnt   <= '0;
            drain_cnt <= '0;
            exp1      <= 1'b0;
            vld1      <= 1'b0;
            vld2      <= 1'b0;
        end else begin
            exp1      <= dut_d;
            vld1      <= (state == RUN);
            vld2      <= vld1;
            // High for exactly the RST cycle.
            dut_reset <= accept;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;

            if (accept) begin
                dut_d   <= 1'b0;
                err_cnt <= '0;
                vec_cnt <= '0;
            end else begin
                if (state == RST) begin
                    dut_d <= 1'b0;
                end else if (state == RUN) begin
                    dut_d   <= lfsr_bit;
                    vec_cnt <= vec_cnt + 1'b1;
                end
                if (err_hit && (err_cnt != CNT_MAX)) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

`ifdef DFF_BIST_FIRST_FAIL_EN
    // Counts pipeline compares in this run, i.e. the index of the vector being checked.
    logic [CNT_W-1:0] cmp_idx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cmp_idx        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (accept) begin
            cmp_idx        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            if (vld2) begin
                cmp_idx <= cmp_idx + 1'b1;
            end
            if (err_hit && !first_fail_vld) begin
                first_fail_vld <= 1'b1;
                first_fail     <= chk_err ? CNT_MAX : cmp_idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dff_bist_ctrl.sv
module tb_dff_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic       start_b;

    // Default-parameter instance and its DFF model.
    logic       dut_d, dut_reset, dut_q, dut_qbar, busy, done, pass;
    logic [7:0] err_cnt, vec_cnt;
    int         fault_mode;   // 0 good, 1 qbar tied to q, 2 q stuck-at-0, 3 inverted q
    logic       dff_st;

    always @(posedge clk) dff_st <= dut_reset ? 1'b0 : dut_d;

    always_comb begin
        case (fault_mode)
            2:       dut_q = 1'b0;
            3:       dut_q = ~dff_st;
            default: dut_q = dff_st;
        endcase
        dut_qbar = (fault_mode == 1) ? dut_q : ~dut_q;
    end

    // Large instances, both wired to an inverted-q DFF.
    logic       d1, r1, st1, busy1, done1, pass1;
    logic [8:0] err1, vec1;
    logic       d2, r2, st2, busy2, done2, pass2;
    logic [7:0] err2, vec2;

    always @(posedge clk) st1 <= r1 ? 1'b0 : d1;
    always @(posedge clk) st2 <= r2 ? 1'b0 : d2;

`ifdef DFF_BIST_FIRST_FAIL_EN
    logic [7:0] ff0, ff2;
    logic [8:0] ff1;
    logic       ffv0, ffv1, ffv2;
`endif

    dff_bist_ctrl u_dut (
        .clk (clk), .reset (reset), .start (start),
        .dut_d (dut_d), .dut_reset (dut_reset), .dut_q (dut_q), .dut_qbar (dut_qbar),
        .busy (busy), .done (done), .pass (pass), .err_cnt (err_cnt),
`ifdef DFF_BIST_FIRST_FAIL_EN
        .first_fail (ff0), .first_fail_vld (ffv0),
`endif
        .vec_cnt (vec_cnt)
    );

    dff_bist_ctrl #(.NUM_TESTS (300), .CNT_W (9)) u_big1 (
        .clk (clk), .reset (reset), .start (start_b),
        .dut_d (d1), .dut_reset (r1), .dut_q (~st1), .dut_qbar (st1),
        .busy (busy1), .done (done1), .pass (pass1), .err_cnt (err1),
`ifdef DFF_BIST_FIRST_FAIL_EN
        .first_fail (ff1), .first_fail_vld (ffv1),
`endif
        .vec_cnt (vec1)
    );

    dff_bist_ctrl #(.NUM_TESTS (255), .CNT_W (8)) u_big2 (
        .clk (clk), .reset (reset), .start (start_b),
        .dut_d (d2), .dut_reset (r2), .dut_q (~st2), .dut_qbar (st2),
        .busy (busy2), .done (done2), .pass (pass2), .err_cnt (err2),
`ifdef DFF_BIST_FIRST_FAIL_EN
        .first_fail (ff2), .first_fail_vld (ffv2),
`endif
        .vec_cnt (vec2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference stimulus: first 16 LSBs of a right-shift Galois LFSR, mask B400, seed ACE1.
    function automatic logic [15:0] model_bits();
        logic [15:0] s;
        logic [15:0] b;
        s = 16'hACE1;
        b = '0;
        for (int i = 0; i < 16; i++) begin
            b[i] = s[0];
            s    = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        end
        return b;
    endfunction

    function automatic int popcount16(input logic [15:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        return n;
    endfunction

    // One complete run from an accepted start; c counts edges after the accept edge.
    task automatic run_once(input int idx, input int mode, input int mid_start,
                            input int exp_err, input int exp_pass);
        logic [15:0] seq;
        int          rst_hi;
        int          done_at;
        string       tag;
        tag        = $sformatf("run%0d", idx);
        fault_mode = mode;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, ".busy_after_start"}, busy, 1);
        check({tag, ".dut_reset_in_rst"}, dut_reset, 1);
        rst_hi  = 1;
        seq     = '0;
        done_at = -1;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            if (c == mid_start) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            if (dut_reset) rst_hi++;
            if (c >= 3 && c <= 18) seq[c-3] = dut_d;
            if (done) done_at = c;
        end
        check({tag, ".done_latency"}, done_at, 20);
        check({tag, ".err_cnt"}, err_cnt, exp_err);
        check({tag, ".pass"}, pass, exp_pass);
        check({tag, ".vec_cnt"}, vec_cnt, 16);
        check({tag, ".busy_in_done"}, busy, 0);
        check({tag, ".dut_d_seq"}, seq, model_bits());
        check({tag, ".dut_reset_pulses"}, rst_hi, 1);
    endtask

    typedef struct {
        int mode;
        int mid_start;
        int exp_err;
        int exp_pass;
    } vec_t;

    vec_t tbl[5];

    initial begin
        // mode, cycle of an extra start pulse (0 none), expected err_cnt, expected pass
        tbl[0] = '{0, 0,  0, 1};                           // good DFF from IDLE
        tbl[1] = '{1, 0, 17, 0};                           // qbar tied to q: CHK + 16 compares
        tbl[2] = '{2, 0, popcount16(model_bits()), 0};     // q stuck-at-0: one error per '1'
        tbl[3] = '{0, 8,  0, 1};                           // start during RUN is ignored
        tbl[4] = '{0, 0,  0, 1};                           // rerun from DONE, same sequence

        reset      = 1'b0;
        start      = 1'b0;
        start_b    = 1'b0;
        fault_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.pass", pass, 0);
        check("rst.err_cnt", err_cnt, 0);
        check("rst.vec_cnt", vec_cnt, 0);
        check("rst.dut_reset", dut_reset, 0);
        check("rst.dut_d", dut_d, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 check("idle.no_start_busy", busy, 0);

        for (int i = 0; i < 5; i++) begin
            run_once(i, tbl[i].mode, tbl[i].mid_start, tbl[i].exp_err, tbl[i].exp_pass);
        end

        // Reset mid-run at vec_cnt==5 with a faulty DFF so err_cnt is non-zero beforehand.
        begin
            int found;
            fault_mode = 1;
            found      = 0;
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            for (int c = 0; c < 30 && found == 0; c++) begin
                @(posedge clk);
                #1;
                if (vec_cnt == 8'd5) found = 1;
            end
            check("midrst.reached_vec5", found, 1);
            check("midrst.err_before", err_cnt, 4);
            reset = 1'b0;
            @(posedge clk);
            #1 reset = 1'b1;
            check("midrst.busy", busy, 0);
            check("midrst.done", done, 0);
            check("midrst.err_cnt", err_cnt, 0);
            check("midrst.vec_cnt", vec_cnt, 0);
            check("midrst.dut_reset", dut_reset, 0);
            @(posedge clk);
            #1;
            check("midrst.stays_idle", busy, 0);
            check("midrst.no_done", done, 0);
            run_once(5, 0, 0, 0, 1);
        end

        // Large runs: CHK fails and every vector fails on an inverted-q DFF.
        begin
            int fin;
            fin = 0;
            @(negedge clk);
            start_b = 1'b1;
            @(posedge clk);
            #1 start_b = 1'b0;
            for (int c = 0; c < 400 && fin == 0; c++) begin
                @(posedge clk);
                #1;
                if (done1 && done2) fin = 1;
            end
            check("big.both_done", fin, 1);
            check("big1.err_cnt", err1, 301);
            check("big1.vec_cnt", vec1, 300);
            check("big1.pass", pass1, 0);
            check("big2.err_saturated", err2, 255);
            check("big2.vec_cnt", vec2, 255);
            check("big2.pass", pass2, 0);
`ifdef DFF_BIST_FIRST_FAIL_EN
            check("big1.first_fail", ff1, 9'h1FF);
            check("big1.first_fail_vld", ffv1, 1);
            check("big2.first_fail", ff2, 8'hFF);
            check("big2.first_fail_vld", ffv2, 1);
            check("main.first_fail_vld_clean", ffv0, 0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
